// File: rtl/slot_reel_driver.sv
// Two-reel slot machine driver: start/stop button FSM, prescaled reel advance,
// and a time-multiplexed single 7-segment display for the two reel digits.
module slot_reel_driver #(
  parameter int TICK_DIV = 1048576,
  parameter int STEP2    = 3,
  parameter int MUX_DIV  = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       judge,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dig_sel
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MUX_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);
  localparam logic [3:0]    STEP      = 4'(STEP2);

  typedef enum logic [1:0] {IDLE, SPIN_BOTH, SPIN_R2, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      reel1_q, reel1_d;
  logic [3:0]      reel2_q, reel2_d;
  logic [TW-1:0]   presc_q;
  logic [MW-1:0]   mux_q;
  logic            dig_sel_q;
  logic [6:0]      seg_q;
  logic            judge_q, busy_q;
  logic            start_d_q, stop_d_q;
  logic            start_e, stop_e, tick;

  function automatic logic [3:0] inc_mod10(input logic [3:0] r);
    return (r == 4'd9) ? 4'd0 : r + 4'd1;
  endfunction

  function automatic logic [3:0] add_step_mod10(input logic [3:0] r);
    logic [4:0] s;
    s = {1'b0, r} + {1'b0, STEP};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    start_e = start_btn & ~start_d_q;
    stop_e  = stop_btn & ~stop_d_q;
    tick    = (presc_q == TICK_LAST);
    state_d = state_q;
    reel1_d = reel1_q;
    reel2_d = reel2_q;
    case (state_q)
      IDLE:      if (start_e) state_d = SPIN_BOTH;
      SPIN_BOTH: if (stop_e)  state_d = SPIN_R2;
      SPIN_R2:   if (stop_e)  state_d = DONE;
      DONE:      if (start_e) state_d = SPIN_BOTH;
      default:   state_d = IDLE;
    endcase
    // A reel being stopped on a tick cycle keeps its pre-tick value.
    if (tick && state_q == SPIN_BOTH && !stop_e)
      reel1_d = inc_mod10(reel1_q);
    if (tick && (state_q == SPIN_BOTH || (state_q == SPIN_R2 && !stop_e)))
      reel2_d = add_step_mod10(reel2_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reel1_q   <= 4'd0;
      reel2_q   <= 4'd0;
      judge_q   <= 1'b0;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      mux_q     <= '0;
      dig_sel_q <= 1'b0;
      seg_q     <= 7'h40;
      start_d_q <= 1'b0;
      stop_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      reel1_q   <= reel1_d;
      reel2_q   <= reel2_d;
      // Status flags follow the next state so judge drops on the restart edge.
      judge_q   <= (state_d == DONE);
      busy_q    <= (state_d == SPIN_BOTH) || (state_d == SPIN_R2);
      presc_q   <= tick ? '0 : presc_q + 1'b1;
      if (mux_q == MUX_LAST) begin
        mux_q     <= '0;
        dig_sel_q <= ~dig_sel_q;
      end else begin
        mux_q <= mux_q + 1'b1;
      end
      seg_q     <= seg_code(dig_sel_q ? reel2_q : reel1_q);
      start_d_q <= start_btn;
      stop_d_q  <= stop_btn;
    end
  end

  assign reel1   = reel1_q;
  assign reel2   = reel2_q;
  assign judge   = judge_q;
  assign busy    = busy_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule
